riscv_prefetch_queue: RTL and testbench
=======================================

# riscv_prefetch_queue

Parametrised instruction prefetch unit that replaces the single-word fetch path between instruction memory and the decoder. It keeps the fetch address running ahead of execution and buffers up to `DEPTH` fetched instructions with their addresses in a FIFO. On a redirect (branch, jump, exception, mret) it flushes the buffered instructions and restarts at the target. Any memory request still in flight at the redirect completes on the bus and its data is discarded.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: instruction word width.
- `BOOT_ADDR`, default 0: first fetch address after reset; 4-byte aligned.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_i`  in  1  fetch enable; 0 stops new memory requests and leaves buffered instructions in place.
- `target_addr_i`  in  ADDR_WIDTH  redirect address; bits [1:0] are ignored and treated as 0.
- `target_valid_i`  in  1  redirect strobe; flushes the FIFO and loads the fetch PC.
- `retire_inst_i`  in  1  pops the head entry.
- `instr_o`  out  DATA_WIDTH  head instruction.
- `instr_addr_o`  out  ADDR_WIDTH  head instruction address.
- `instr_valid_o`  out  1  head entry is valid.
- `imem_valid_o`  out  1  memory request valid.
- `imem_ready_i`  in  1  memory response; `imem_rdata_i` is valid in this cycle.
- `imem_addr_o`  out  ADDR_WIDTH  request address.
- `imem_wdata_o`  out  DATA_WIDTH  tied to 0.
- `imem_we_o`  out  4  tied to 0.
- `imem_rdata_i`  in  DATA_WIDTH  read data.

## Operation

- State machine:
  - IDLE: no request outstanding.
  - REQ: request outstanding; its response will be kept.
  - REQ_DISCARD: request outstanding; its response will be dropped.
- Slot reservation: a request may issue only when `req_i`=1 and `count` + (outstanding ? 1 : 0) < `DEPTH`.
  - Consequence: a FIFO write never occurs when the FIFO is full.
  - `count` is `$clog2(DEPTH+1)` bits wide.
- Issue:
  - IDLE→REQ when the issue condition holds.
  - `imem_valid_o` and `imem_addr_o` are registered.
  - They must stay stable until the cycle in which `imem_ready_i`=1.
- Response handling, in a cycle with `imem_ready_i`=1:
  - In REQ: write {`imem_addr_o`, `imem_rdata_i`} into the FIFO; fetch PC += 4, wrapping modulo 2^ADDR_WIDTH.
  - In REQ_DISCARD: drop the data; the fetch PC is not advanced.
  - Next state is REQ if the issue condition holds (evaluated with the updated count), otherwise IDLE. Back-to-back requests are therefore allowed.
- Redirect (`target_valid_i`=1):
  - Clear the FIFO (pointers and count to 0).
  - fetch PC ← {`target_addr_i`[ADDR_WIDTH-1:2], 2'b00}.
  - If in REQ and `imem_ready_i`=0: go to REQ_DISCARD, keeping `imem_valid_o` and `imem_addr_o` stable.
  - If `imem_ready_i`=1 in the same cycle: that response is dropped.
  - Redirect in IDLE: the new request may issue in the following cycle.
- Pop:
  - `retire_inst_i`=1 with `instr_valid_o`=1 advances the read pointer.
  - `retire_inst_i`=1 when empty is ignored.
- Simultaneous events:
  - Redirect and retire in the same cycle: the redirect wins and the retire is discarded.
  - Write and pop in the same cycle: both occur and `count` is unchanged.
- Outputs when empty: `instr_o`=0 and `instr_addr_o`=0 whenever `instr_valid_o`=0.

## Timing

- Values after reset:
  - `imem_valid_o`=0
  - `imem_addr_o`=`BOOT_ADDR`
  - `instr_valid_o`=0, `instr_o`=0, `instr_addr_o`=0
  - FIFO empty, state IDLE
- First request: `imem_valid_o`=1 in the first cycle after `rst` deasserts, provided `req_i`=1.
- Reset during a request: the request is abandoned and `imem_valid_o`=0 in the next cycle. The memory must tolerate an abandoned request.
- Fill latency, without bypass: response in cycle N → `instr_valid_o`=1 in cycle N+1.
- Flush latency: `target_valid_i` in cycle N → `instr_valid_o`=0 in cycle N+1.
- Sustained throughput: one instruction per cycle when the memory returns `imem_ready_i`=1 every cycle.

## Configuration

- `PREFETCH_BYPASS_EN` defined:
  - When the FIFO is empty and a kept response arrives, `instr_valid_o`=1 and `instr_o`=`imem_rdata_i` combinationally in the same cycle.
  - If `retire_inst_i`=1 in that cycle, the word is consumed and not written into the FIFO.
  - A redirect in the same cycle suppresses the bypass.
- `PREFETCH_BYPASS_EN` undefined:
  - All instructions pass through the FIFO.
  - No combinational path exists from `imem_*` inputs to `instr_*` outputs.

## Test plan

- Reset release, `BOOT_ADDR`=0x100, memory always ready → `imem_addr_o` sequence 0x100, 0x104, 0x108…; `instr_valid_o` first rises in cycle 2, or cycle 1 with bypass.
- `retire_inst_i` held 0, `DEPTH`=4 → exactly 4 responses accepted; `imem_valid_o` stays 0 afterwards. One retire → exactly one further request is issued.
- Request to 0x108 outstanding with ready delayed 3 cycles, redirect to 0x2002 → 0x108 stays on the bus until ready; its data is dropped; next request is 0x2000; first valid head is `instr_addr_o`=0x2000.
- `target_valid_i` and `retire_inst_i` together with a 3-entry FIFO → FIFO empty, `instr_valid_o`=0 next cycle; no underflow on the retire.
- Fetch PC 0xFFFFFFFC with a kept response → next `imem_addr_o` is 0x00000000.
- `req_i`=0 mid-stream → the outstanding request completes; no new request is issued; buffered entries stay valid and can still be retired.

Source files
------------

// File: rtl/riscv_prefetch_queue.sv
// riscv_prefetch_queue: runs the fetch PC ahead of execution and buffers DEPTH fetched words.
// Build option PREFETCH_BYPASS_EN forwards a kept response straight to the head when the FIFO is empty.
module riscv_prefetch_queue #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] target_addr_i,
    input  logic                  target_valid_i,
    input  logic                  retire_inst_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_valid_o,
    output logic                  imem_valid_o,
    input  logic                  imem_ready_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [DATA_WIDTH-1:0] imem_wdata_o,
    output logic [3:0]            imem_we_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REQ_DISCARD
    } state_t;

    state_t                           state;
    logic [ADDR_WIDTH-1:0]            fetch_pc;
    logic [ADDR_WIDTH-1:0]            pc_next;
    logic [ADDR_WIDTH-1:0]            target_pc;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_mem [DEPTH];
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
    logic [PW-1:0]                    rd_ptr;
    logic [PW-1:0]                    wr_ptr;
    logic [CW-1:0]                    count;
    logic [CW-1:0]                    count_next;
    logic                             fifo_empty;
    logic                             resp_kept;
    logic                             bypass_take;
    logic                             fifo_wr;
    logic                             fifo_rd;
    logic                             unused_target_lsbs;

    assign imem_wdata_o       = '0;
    assign imem_we_o          = '0;
    assign unused_target_lsbs = ^target_addr_i[1:0];

    assign target_pc  = {target_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign resp_kept  = (state == REQ) && imem_ready_i && !target_valid_i;

`ifdef PREFETCH_BYPASS_EN
    assign bypass_take = resp_kept && fifo_empty && retire_inst_i;
`else
    assign bypass_take = 1'b0;
`endif

    assign fifo_wr = resp_kept && !bypass_take;
    assign fifo_rd = retire_inst_i && !fifo_empty && !target_valid_i;

    always_comb begin
        instr_valid_o = 1'b0;
        instr_o       = '0;
        instr_addr_o  = '0;
        if (!fifo_empty) begin
            instr_valid_o = 1'b1;
            instr_addr_o  = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
            instr_o       = head[DATA_WIDTH-1:0];
        end
`ifdef PREFETCH_BYPASS_EN
        else if (resp_kept) begin
            instr_valid_o = 1'b1;
            instr_addr_o  = imem_addr_o;
            instr_o       = imem_rdata_i;
        end
`endif
    end

    // Occupancy after this cycle; a response may only reissue into a slot that is free by then.
    always_comb begin
        count_next = count;
        if (target_valid_i) begin
            count_next = '0;
        end else if (fifo_wr && !fifo_rd) begin
            count_next = count + CW'(1);
        end else if (!fifo_wr && fifo_rd) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        pc_next = fetch_pc;
        if (target_valid_i) begin
            pc_next = target_pc;
        end else if (resp_kept) begin
            pc_next = fetch_pc + ADDR_WIDTH'(4);
        end
    end

    // Bus request address is held until ready even across a redirect, so the
    // fetch PC is kept separately and only copied onto the bus at issue time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            imem_valid_o <= 1'b0;
            imem_addr_o  <= BOOT_ADDR;
            fetch_pc     <= BOOT_ADDR;
        end else begin
            fetch_pc <= pc_next;
            case (state)
                IDLE: begin
                    if (!target_valid_i && req_i && (count < FULL)) begin
                        state        <= REQ;
                        imem_valid_o <= 1'b1;
                        imem_addr_o  <= fetch_pc;
                    end
                end
                REQ, REQ_DISCARD: begin
                    if (imem_ready_i) begin
                        if (req_i && (count_next < FULL)) begin
                            state        <= REQ;
                            imem_valid_o <= 1'b1;
                            imem_addr_o  <= pc_next;
                        end else begin
                            state        <= IDLE;
                            imem_valid_o <= 1'b0;
                        end
                    end else if (target_valid_i) begin
                        state <= REQ_DISCARD;
                    end
                end
                default: begin
                    state        <= IDLE;
                    imem_valid_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (target_valid_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (fifo_wr) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (fifo_rd) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= {imem_addr_o, imem_rdata_i};
        end
    end

endmodule

// File: tb/tb_riscv_prefetch_queue.sv
// Testbench for riscv_prefetch_queue: directed fetch/redirect/wrap scenarios, then random
// traffic, all checked each cycle against a queue-based reference of the prefetcher.
module tb_riscv_prefetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_0100;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [31:0] target_addr_i;
    logic        target_valid_i;
    logic        retire_inst_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_valid_o;
    logic        imem_valid_o;
    logic        imem_ready_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic [3:0]  imem_we_o;
    logic [31:0] imem_rdata_i;

    int total = 0;
    int bad   = 0;

    // Reference: buffered words as queues, plus one outstanding bus request.
    logic [31:0] q_a[$];
    logic [31:0] q_d[$];
    bit          m_out;
    bit          m_keep;
    bit          m_init = 1'b0;
    logic [31:0] m_addr;
    logic [31:0] m_pc;

    riscv_prefetch_queue #(
        .DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BOOT_ADDR(BOOT)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i),
        .target_addr_i(target_addr_i), .target_valid_i(target_valid_i),
        .retire_inst_i(retire_inst_i),
        .instr_o(instr_o), .instr_addr_o(instr_addr_o), .instr_valid_o(instr_valid_o),
        .imem_valid_o(imem_valid_o), .imem_ready_i(imem_ready_i),
        .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
        .imem_we_o(imem_we_o), .imem_rdata_i(imem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelIssue();
        m_out  = 1'b1;
        m_keep = 1'b1;
        m_addr = m_pc;
    endtask

    task automatic modelUpdate(input bit r, input bit rq, input bit tv, input logic [31:0] ta,
                               input bit ret, input bit rdy, input logic [31:0] rd);
        bit resp;
        bit took_bypass;
        int n_before;
        if (r) begin
            q_a.delete();
            q_d.delete();
            m_out  = 1'b0;
            m_keep = 1'b0;
            m_addr = BOOT;
            m_pc   = BOOT;
            m_init = 1'b1;
            return;
        end
        resp        = m_out && rdy;
        n_before    = q_a.size();
        took_bypass = 1'b0;
        if (tv) begin
            q_a.delete();
            q_d.delete();
            m_pc = ta & 32'hFFFF_FFFC;
            if (resp) begin
                m_out = 1'b0;
                if (rq) modelIssue();
            end else if (m_out) begin
                m_keep = 1'b0;
            end
        end else begin
            if (ret && n_before > 0) begin
                void'(q_a.pop_front());
                void'(q_d.pop_front());
            end else if (ret && BYP && resp && m_keep && n_before == 0) begin
                took_bypass = 1'b1;
            end
            if (resp) begin
                if (m_keep) begin
                    if (!took_bypass) begin
                        q_a.push_back(m_addr);
                        q_d.push_back(rd);
                    end
                    m_pc = m_pc + 32'd4;
                end
                m_out = 1'b0;
                if (rq && q_a.size() < DEPTH) modelIssue();
            end else if (!m_out) begin
                if (rq && n_before < DEPTH) modelIssue();
            end
        end
    endtask

    // Drive one cycle of inputs, compare every output with the reference, then clock.
    task automatic applyStimulus(input bit r, input bit rq, input bit tv, input logic [31:0] ta,
                                 input bit ret, input bit rdy, input logic [31:0] rd);
        logic        e_v;
        logic [31:0] e_a;
        logic [31:0] e_d;
        rst            = r;
        req_i          = rq;
        target_valid_i = tv;
        target_addr_i  = ta;
        retire_inst_i  = ret;
        imem_ready_i   = rdy;
        imem_rdata_i   = rd;
        #1;
        if (m_init) begin
            e_v = 1'b0;
            e_a = '0;
            e_d = '0;
            if (q_a.size() > 0) begin
                e_v = 1'b1;
                e_a = q_a[0];
                e_d = q_d[0];
            end else if (BYP && m_out && m_keep && rdy && !tv) begin
                e_v = 1'b1;
                e_a = m_addr;
                e_d = rd;
            end
            checkOutput("imem_valid", imem_valid_o, m_out);
            checkOutput("imem_addr", imem_addr_o, m_addr);
            checkOutput("instr_valid", instr_valid_o, e_v);
            checkOutput("instr_addr", instr_addr_o, e_a);
            checkOutput("instr", instr_o, e_d);
        end
        modelUpdate(r, rq, tv, ta, ret, rdy, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit          r_r;
        bit          r_rq;
        bit          r_tv;
        bit          r_ret;
        bit          r_rdy;
        logic [31:0] r_ta;

        // Boot fill with memory always ready, then FIFO-full stall and single-retire refill.
        doReset();
        checkOutput("reset_imem_valid", imem_valid_o, 1'b0);
        checkOutput("reset_imem_addr", imem_addr_o, BOOT);
        checkOutput("reset_instr_valid", instr_valid_o, 1'b0);
        applyStimulus(0, 1, 0, 0, 0, 0, $urandom);
        checkOutput("first_req_valid", imem_valid_o, 1'b1);
        checkOutput("first_req_addr", imem_addr_o, 32'h100);
        checkOutput("cycle1_instr_valid", instr_valid_o, 1'b0);
        applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        checkOutput("seq_addr_104", imem_addr_o, 32'h104);
        checkOutput("cycle2_instr_valid", instr_valid_o, 1'b1);
        applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        checkOutput("seq_addr_108", imem_addr_o, 32'h108);
        applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        checkOutput("seq_addr_10c", imem_addr_o, 32'h10C);
        applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        checkOutput("full_stops_req", imem_valid_o, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, $urandom);
        checkOutput("full_stays_idle", imem_valid_o, 1'b0);
        applyStimulus(0, 1, 0, 0, 1, 0, $urandom);
        applyStimulus(0, 1, 0, 0, 0, 0, $urandom);
        checkOutput("refill_req_valid", imem_valid_o, 1'b1);
        checkOutput("refill_req_addr", imem_addr_o, 32'h110);
        applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        checkOutput("refill_only_one", imem_valid_o, 1'b0);

        // Redirect while 0x108 waits on a slow memory.
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0, $urandom);
        applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        checkOutput("pending_addr", imem_addr_o, 32'h108);
        applyStimulus(0, 1, 1, 32'h2002, 0, 0, $urandom);
        checkOutput("discard_hold_valid", imem_valid_o, 1'b1);
        checkOutput("discard_hold_addr", imem_addr_o, 32'h108);
        applyStimulus(0, 1, 0, 0, 0, 0, $urandom);
        applyStimulus(0, 1, 0, 0, 0, 0, $urandom);
        checkOutput("discard_hold_addr2", imem_addr_o, 32'h108);
        applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        checkOutput("redirect_req_addr", imem_addr_o, 32'h2000);
        applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        checkOutput("redirect_head_addr", instr_addr_o, 32'h2000);

        // Redirect and retire together with three buffered words.
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0, $urandom);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        applyStimulus(0, 1, 1, 32'h300, 1, 0, $urandom);
        checkOutput("flush_instr_valid", instr_valid_o, 1'b0);
        checkOutput("flush_keeps_bus", imem_addr_o, 32'h10C);
        applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        checkOutput("flush_next_addr", imem_addr_o, 32'h300);

        // Address wrap at the top of memory, then fetch disabled mid-stream.
        doReset();
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0, $urandom);
        checkOutput("idle_redirect_no_req", imem_valid_o, 1'b0);
        applyStimulus(0, 1, 0, 0, 0, 0, $urandom);
        checkOutput("wrap_req_addr", imem_addr_o, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
        checkOutput("wrap_next_addr", imem_addr_o, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, $urandom);
        checkOutput("req_off_no_issue", imem_valid_o, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, $urandom);
        applyStimulus(0, 0, 0, 0, 0, 0, $urandom);
        checkOutput("req_off_still_idle", imem_valid_o, 1'b0);
        checkOutput("req_off_buffered", instr_valid_o, 1'b1);
        applyStimulus(0, 0, 0, 0, 1, 0, $urandom);
        applyStimulus(0, 0, 0, 0, 1, 0, $urandom);
        checkOutput("drained", instr_valid_o, 1'b0);
        checkOutput("wdata_tied", imem_wdata_o, 32'h0);
        checkOutput("we_tied", imem_we_o, 32'h0);
        $display("[TB] directed scenarios complete, starting random traffic");

        // Random traffic: occasional resets and redirects, memory ready only when a request is out.
        for (int i = 0; i < 3000; i++) begin
            r_r   = ($urandom_range(0, 249) == 0);
            r_rq  = ($urandom_range(0, 9) != 0);
            r_tv  = ($urandom_range(0, 19) == 0);
            r_ret = ($urandom_range(0, 99) < 55);
            r_rdy = m_out && ($urandom_range(0, 99) < 65);
            r_ta  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
            applyStimulus(r_r, r_rq, r_tv, r_ta, r_ret, r_rdy, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
